alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle combinational ALU: same 8-op encoding, generic data width, configurable register depth.
- Adds valid/ready handshakes with full backpressure, a pass-through tag, and synchronous flush.
- Sits between issue logic and writeback; accepts up to one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8)
- STAGES, 2, pipeline register slots between accept and output (1..4); unstalled latency = STAGES cycles
- TAG_W, 4, width of opaque tag carried alongside each op

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; drops all in-flight ops
- in_valid  in  1  op presented
- in_ready  out  1  block accepts op this cycle
- aluop  in  3  operation select
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- in_tag  in  TAG_W  tag for this op
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- f  out  WIDTH  result
- out_tag  out  TAG_W  tag of presented result

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: all slot valids, f and out_tag clear to 0; out_valid=0; in_ready=1 once rst_n deasserts. Reset mid-operation discards every in-flight op; no partial output.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - out_valid, f and out_tag hold stable until transfer.
  - in_valid may drop without a transfer.
- Ops (SH = b[$clog2(WIDTH)-1:0], upper b bits ignored for shifts):
  - 0 add: a+b, mod 2^WIDTH
  - 1 sll: a << SH
  - 2 sra: arithmetic a >>> SH
  - 3 sub: a-b, mod 2^WIDTH
  - 4 xor: a^b
  - 5 srl: logical a >> SH
  - 6 or: a|b
  - 7 and: a&b
- Datapath: result computed combinationally at accept and captured into slot 0. Slots 0..STAGES-1 form a shift chain; slot STAGES-1 drives outputs.
- Slot advance: slot k moves to k+1 when k+1 is empty or k+1 is itself advancing. The last slot advances on an output transfer.
- in_ready = !slot0.valid || slot0 advancing. Combinational from out_ready; no combinational path from in_valid to in_ready.
- Throughput: one op/cycle when out_ready is held high. Full block holds STAGES ops; a full block with out_ready=0 drives in_ready=0.
- Simultaneous accept and output transfer while full: both occur; occupancy unchanged.
- flush (priority over everything):
  - Next cycle all valids = 0.
  - An op presented in the flush cycle is not accepted: in_ready=0 while flush=1.
  - An output transfer in the flush cycle still counts as completed.
- Ordering: results emerge in accept order; tags unchanged.

Optional Feature:
- Macro ALU_PIPE_FLAGS_EN.
- Defined: adds output port flags[3:0] = {N,Z,C,V}, registered with f and following identical valid/hold rules.
  - N = f[WIDTH-1]; Z = (f==0).
  - add: C = carry-out; V = signed overflow.
  - sub: C = 1 when a >= b unsigned (no borrow); V = signed overflow.
  - All other ops: C=0, V=0.
  - Resets to 0.
- Undefined: flags port absent; no flag logic.

Decomposition:
- Package alu_pipe_pkg:
  - typedef enum logic [2:0] alu_op_t {ALU_ADD, ALU_SLL, ALU_SRA, ALU_SUB, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND}
  - flag bit index constants
- Sub-module alu_core: purely combinational op evaluation (and flags when enabled). alu_pipe owns the slot chain, handshakes and flush.

Test Plan:
- Op sweep: WIDTH=32, STAGES=2, out_ready=1, a=32'h800055AA, b=32'h4, aluop 0..7 back-to-back -> f = 800055AE, 00055AA0, F800055A, 800055A6, 800055AE, 0800055A, 800055AE, 00000000; each valid exactly 2 cycles after accept; one result/cycle; tags in order.
- Backpressure: hold out_ready=0 while streaming 4 ops -> in_ready falls after 2 accepts; f/out_tag stable. Release -> remaining ops drain in order, none lost or duplicated.
- Flush: 2 ops in flight, flush=1 with in_valid=1 -> in_ready=0 that cycle; out_valid=0 next cycle; nothing from either op emerges.
- Async reset mid-stream: drop rst_n between edges -> out_valid=0 and f=0 immediately. After release, first accepted op a=1, b=2, add -> f=3.
- Shift masking: WIDTH=16, a=16'h8001, b=16'h0011, srl -> 16'h4000 (SH=1); sra -> 16'hC000.
- Flags (ALU_PIPE_FLAGS_EN): 7FFFFFFF+1 -> f=80000000, flags N=1 Z=0 C=0 V=1; sub 5-5 -> Z=1 C=1; and of 800055AA,4 -> Z=1.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared types and constants for the pipelined ALU.
//   alu_op_t     : 3-bit operation encoding, unchanged from the single-cycle ALU
//   FLAG_*       : bit positions inside the {N,Z,C,V} flags vector
//                  (the flags vector is used only when ALU_PIPE_FLAGS_EN is defined)
package alu_pipe_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SLL = 3'd1,
      ALU_SRA = 3'd2,
      ALU_SUB = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SRL = 3'd5,
      ALU_OR  = 3'd6,
      ALU_AND = 3'd7
   } alu_op_t;

   localparam int unsigned FLAG_W = 4;
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake bundle between issue logic, the ALU pipe and writeback.
//   Issue side  : in_valid, in_ready, aluop, a, b, in_tag
//   Result side : out_valid, out_ready, f, out_tag (+ flags with ALU_PIPE_FLAGS_EN)
//   modport master : the block driving ops and consuming results
//   modport slave  : the ALU pipe itself
interface alu_pipe_if
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4
)
();
   import alu_pipe_pkg::*;

   logic             in_valid;
   logic             in_ready;
   alu_op_t          aluop;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic [TAG_W-1:0] out_tag;

`ifdef ALU_PIPE_FLAGS_EN
   logic [FLAG_W-1:0] flags;

   modport master (
      output in_valid, aluop, a, b, in_tag, out_ready,
      input  in_ready, out_valid, f, out_tag, flags
   );

   modport slave (
      input  in_valid, aluop, a, b, in_tag, out_ready,
      output in_ready, out_valid, f, out_tag, flags
   );
`else
   modport master (
      output in_valid, aluop, a, b, in_tag, out_ready,
      input  in_ready, out_valid, f, out_tag
   );

   modport slave (
      input  in_valid, aluop, a, b, in_tag, out_ready,
      output in_ready, out_valid, f, out_tag
   );
`endif

endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational evaluation of one ALU operation.
//   op    : operation select (alu_op_t)
//   a, b  : operands; shifts use only the low $clog2(WIDTH) bits of b
//   f     : result
//   flags : {N,Z,C,V}, present only when ALU_PIPE_FLAGS_EN is defined
module alu_core
   import alu_pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32
)
(
   input  alu_op_t           op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [WIDTH-1:0]  f
`ifdef ALU_PIPE_FLAGS_EN
   ,
   output logic [FLAG_W-1:0] flags
`endif
);

   localparam int unsigned SHW = $clog2(WIDTH);

   logic [SHW-1:0] sh;

   assign sh = b[SHW-1:0];

   always_comb begin
      f = '0;
      case (op)
         ALU_ADD: f = a + b;
         ALU_SLL: f = a << sh;
         ALU_SRA: f = $signed(a) >>> sh;
         ALU_SUB: f = a - b;
         ALU_XOR: f = a ^ b;
         ALU_SRL: f = a >> sh;
         ALU_OR:  f = a | b;
         ALU_AND: f = a & b;
         default: f = '0;
      endcase
   end

`ifdef ALU_PIPE_FLAGS_EN
   logic [WIDTH:0] sum_x;

   assign sum_x = {1'b0, a} + {1'b0, b};

   // Overflow: add overflows when like-signed operands give a result of the
   // other sign; sub overflows when unlike-signed operands do.
   always_comb begin
      flags         = '0;
      flags[FLAG_N] = f[WIDTH-1];
      flags[FLAG_Z] = (f == '0);
      case (op)
         ALU_ADD: begin
            flags[FLAG_C] = sum_x[WIDTH];
            flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            flags[FLAG_C] = (a >= b);
            flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (f[WIDTH-1] != a[WIDTH-1]);
         end
         default: begin
            flags[FLAG_C] = 1'b0;
            flags[FLAG_V] = 1'b0;
         end
      endcase
   end
`endif

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready handshakes, tag pass-through and flush.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards every in-flight op
//   flush : synchronous; empties all slots next cycle, blocks accept this cycle
//   bus   : alu_pipe_if.slave (in_valid/in_ready/aluop/a/b/in_tag,
//           out_valid/out_ready/f/out_tag, flags with ALU_PIPE_FLAGS_EN)
// The result is computed at accept into slot 0 and shifts through STAGES slots;
// the last slot drives the outputs. Optional feature macro: ALU_PIPE_FLAGS_EN.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4
)
(
   input logic       clk,
   input logic       rst_n,
   input logic       flush,
   alu_pipe_if.slave bus
);

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  dat [STAGES];
   logic [TAG_W-1:0]  tg  [STAGES];
   logic [WIDTH-1:0]  res;
   logic              room;
   logic              in_rdy;
   logic              accept;

`ifdef ALU_PIPE_FLAGS_EN
   logic [FLAG_W-1:0] flg [STAGES];
   logic [FLAG_W-1:0] res_flags;
`endif

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op    (bus.aluop),
      .a     (bus.a),
      .b     (bus.b),
`ifdef ALU_PIPE_FLAGS_EN
      .flags (res_flags),
`endif
      .f     (res)
   );

   // Walk from the output slot back to slot 0 carrying "the slot ahead can
   // take data this cycle"; a scalar carry keeps the chain free of
   // self-referencing vector bits. After the walk, room is slot 0's.
   always_comb begin
      adv  = '0;
      room = bus.out_ready;
      for (int unsigned i = 0; i < STAGES; i++) begin
         adv[STAGES-1-i] = vld[STAGES-1-i] && room;
         room            = !vld[STAGES-1-i] || room;
      end
   end

   assign in_rdy       = room && !flush;
   assign accept       = bus.in_valid && in_rdy;
   assign bus.in_ready = in_rdy;

   assign bus.out_valid = vld[STAGES-1];
   assign bus.f         = dat[STAGES-1];
   assign bus.out_tag   = tg[STAGES-1];
`ifdef ALU_PIPE_FLAGS_EN
   assign bus.flags     = flg[STAGES-1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int unsigned k = 0; k < STAGES; k++) begin
            dat[k] <= '0;
            tg[k]  <= '0;
`ifdef ALU_PIPE_FLAGS_EN
            flg[k] <= '0;
`endif
         end
      end else if (flush) begin
         vld <= '0;
      end else begin
         if (accept) begin
            vld[0] <= 1'b1;
            dat[0] <= res;
            tg[0]  <= bus.in_tag;
`ifdef ALU_PIPE_FLAGS_EN
            flg[0] <= res_flags;
`endif
         end else if (adv[0]) begin
            vld[0] <= 1'b0;
         end
         for (int unsigned k = 1; k < STAGES; k++) begin
            if (adv[k-1]) begin
               vld[k] <= 1'b1;
               dat[k] <= dat[k-1];
               tg[k]  <= tg[k-1];
`ifdef ALU_PIPE_FLAGS_EN
               flg[k] <= flg[k-1];
`endif
            end else if (adv[k]) begin
               vld[k] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe.
//   u_dut32 : WIDTH=32, STAGES=2 (op sweep, backpressure, flush, reset, flags)
//   u_dut16 : WIDTH=16, STAGES=3 (shift-amount masking)
module tb_alu_pipe;
   import alu_pipe_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(32), .TAG_W(4)) bus32 ();
   alu_pipe_if #(.WIDTH(16), .TAG_W(4)) bus16 ();

   alu_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus32.slave)
   );

   alu_pipe #(.WIDTH(16), .STAGES(3), .TAG_W(4)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus16.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive32(input logic v, input alu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t);
      bus32.in_valid = v;
      bus32.aluop    = op;
      bus32.a        = a;
      bus32.b        = b;
      bus32.in_tag   = t;
   endtask

   task automatic drive16(input logic v, input alu_op_t op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] t);
      bus16.in_valid = v;
      bus16.aluop    = op;
      bus16.a        = a;
      bus16.b        = b;
      bus16.in_tag   = t;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] sweep_exp [8];
      int acc;
      int got;

      sweep_exp = '{32'h800055AE, 32'h00055AA0, 32'hF800055A, 32'h800055A6,
                    32'h800055AE, 32'h0800055A, 32'h800055AE, 32'h00000000};

      drive32(1'b0, ALU_ADD, '0, '0, '0);
      drive16(1'b0, ALU_ADD, '0, '0, '0);
      bus32.out_ready = 1'b0;
      bus16.out_ready = 1'b0;

      // reset state
      #22 rst_n = 1'b1;
      #1;
      check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
      check("rst_f",         64'(bus32.f),         64'd0);
      check("rst_out_tag",   64'(bus32.out_tag),   64'd0);
      check("rst_in_ready",  64'(bus32.in_ready),  64'd1);
      tick();

      // op sweep, back-to-back, out_ready high
      bus32.out_ready = 1'b1;
      for (int n = 0; n < 10; n++) begin
         if (n < 8) drive32(1'b1, alu_op_t'(3'(n)), 32'h800055AA, 32'h4, 4'(n));
         else       bus32.in_valid = 1'b0;
         #1;
         if (n < 8) check("sweep_in_ready", 64'(bus32.in_ready), 64'd1);
         if (n >= 2) begin
            check("sweep_out_valid", 64'(bus32.out_valid), 64'd1);
            check("sweep_f",         64'(bus32.f),         64'(sweep_exp[n-2]));
            check("sweep_tag",       64'(bus32.out_tag),   64'(n-2));
         end else begin
            check("sweep_latency",   64'(bus32.out_valid), 64'd0);
         end
         tick();
      end
      check("sweep_drained", 64'(bus32.out_valid), 64'd0);

      // backpressure: ops add (100+k)+k, tags 8+k
      bus32.out_ready = 1'b0;
      acc = 0;
      got = 0;
      for (int n = 0; n < 5; n++) begin
         if (acc < 4) drive32(1'b1, ALU_ADD, 32'(100 + acc), 32'(acc), 4'(8 + acc));
         else         bus32.in_valid = 1'b0;
         #1;
         if (n >= 2) begin
            check("bp_in_ready_low", 64'(bus32.in_ready),  64'd0);
            check("bp_hold_valid",   64'(bus32.out_valid), 64'd1);
            check("bp_hold_f",       64'(bus32.f),         64'd100);
            check("bp_hold_tag",     64'(bus32.out_tag),   64'd8);
         end
         if (bus32.in_valid && bus32.in_ready) acc++;
         tick();
      end
      check("bp_accepted", 64'(acc), 64'd2);
      bus32.out_ready = 1'b1;
      for (int n = 0; n < 12 && got < 4; n++) begin
         if (acc < 4) drive32(1'b1, ALU_ADD, 32'(100 + acc), 32'(acc), 4'(8 + acc));
         else         bus32.in_valid = 1'b0;
         #1;
         if (bus32.in_valid && bus32.in_ready) acc++;
         if (bus32.out_valid) begin
            check("bp_drain_f",   64'(bus32.f),       64'(100 + 2 * got));
            check("bp_drain_tag", 64'(bus32.out_tag), 64'(8 + got));
            got++;
         end
         tick();
      end
      check("bp_drained", 64'(got), 64'd4);
      bus32.in_valid = 1'b0;
      #1;
      check("bp_no_dup", 64'(bus32.out_valid), 64'd0);

      // flush with two ops in flight and a third presented
      bus32.out_ready = 1'b0;
      drive32(1'b1, ALU_ADD, 32'd1, 32'd1, 4'd1);
      tick();
      drive32(1'b1, ALU_ADD, 32'd2, 32'd2, 4'd2);
      tick();
      drive32(1'b1, ALU_ADD, 32'd3, 32'd3, 4'd3);
      flush = 1'b1;
      #1;
      check("flush_in_ready",  64'(bus32.in_ready),  64'd0);
      check("flush_inflight",  64'(bus32.out_valid), 64'd1);
      tick();
      flush = 1'b0;
      bus32.in_valid = 1'b0;
      #1;
      check("flush_cleared", 64'(bus32.out_valid), 64'd0);
      bus32.out_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tick();
         check("flush_no_leak", 64'(bus32.out_valid), 64'd0);
      end

      // asynchronous reset mid-stream
      drive32(1'b1, ALU_ADD, 32'd10, 32'd5, 4'd7);
      tick();
      drive32(1'b1, ALU_ADD, 32'd20, 32'd5, 4'd8);
      tick();
      bus32.in_valid = 1'b0;
      #1;
      check("pre_rst_f", 64'(bus32.f), 64'd15);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", 64'(bus32.out_valid), 64'd0);
      check("arst_f",         64'(bus32.f),         64'd0);
      check("arst_tag",       64'(bus32.out_tag),   64'd0);
      tick();
      tick();
      #3;
      rst_n = 1'b1;
      tick();
      drive32(1'b1, ALU_ADD, 32'd1, 32'd2, 4'd5);
      #1;
      check("post_rst_in_ready", 64'(bus32.in_ready), 64'd1);
      tick();
      bus32.in_valid = 1'b0;
      #1;
      check("post_rst_latency", 64'(bus32.out_valid), 64'd0);
      tick();
      check("post_rst_valid", 64'(bus32.out_valid), 64'd1);
      check("post_rst_f",     64'(bus32.f),         64'd3);
      check("post_rst_tag",   64'(bus32.out_tag),   64'd5);
      tick();

      // shift masking on the 16-bit, 3-stage instance
      bus16.out_ready = 1'b1;
      drive16(1'b1, ALU_SRL, 16'h8001, 16'h0011, 4'd1);
      tick();
      drive16(1'b1, ALU_SRA, 16'h8001, 16'h0011, 4'd2);
      tick();
      bus16.in_valid = 1'b0;
      #1;
      check("w16_latency", 64'(bus16.out_valid), 64'd0);
      tick();
      check("w16_srl_valid", 64'(bus16.out_valid), 64'd1);
      check("w16_srl_f",     64'(bus16.f),         64'h4000);
      check("w16_srl_tag",   64'(bus16.out_tag),   64'd1);
      tick();
      check("w16_sra_f",     64'(bus16.f),         64'hC000);
      check("w16_sra_tag",   64'(bus16.out_tag),   64'd2);
      tick();
      check("w16_drained",   64'(bus16.out_valid), 64'd0);

`ifdef ALU_PIPE_FLAGS_EN
      bus32.out_ready = 1'b1;
      drive32(1'b1, ALU_ADD, 32'h7FFFFFFF, 32'h1, 4'd1);
      tick();
      drive32(1'b1, ALU_SUB, 32'd5, 32'd5, 4'd2);
      tick();
      drive32(1'b1, ALU_AND, 32'h800055AA, 32'h4, 4'd3);
      #1;
      check("flg_add_f",     64'(bus32.f),     64'h80000000);
      check("flg_add_flags", 64'(bus32.flags), 64'b1001);
      tick();
      bus32.in_valid = 1'b0;
      #1;
      check("flg_sub_f",     64'(bus32.f),     64'd0);
      check("flg_sub_flags", 64'(bus32.flags), 64'b0110);
      tick();
      check("flg_and_f",     64'(bus32.f),     64'd0);
      check("flg_and_flags", 64'(bus32.flags), 64'b0100);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
